// File: rtl/big_core_kbd_tx_if.sv
// Command-byte handshake and transfer status between a host controller and the
// PS/2 host-to-device transmitter.
interface big_core_kbd_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx_busy, tx_done, tx_err
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx_busy, tx_done, tx_err
  );
endinterface

// File: rtl/big_core_kbd_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts an
// odd-parity frame on device clock falls and checks the device acknowledge.
module big_core_kbd_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             Clk,
  input  logic             Rst,
  big_core_kbd_tx_if.slave tx,
  input  logic             kbd_clk_in,
  input  logic             kbd_data_in,
  output logic             kbd_clk_oe,
  output logic             kbd_data_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_END
  } state_t;

  state_t        r_state;
  logic [1:0]    r_clk_sync;
  logic [1:0]    r_data_sync;
  logic          r_clk_prev;
  logic [8:0]    r_frame;
  logic [3:0]    r_bit;
  logic [IW-1:0] r_inh;
  logic [TW-1:0] r_tmo;
  logic          r_clk_oe;
  logic          r_data_oe;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic w_clk_s;
  logic w_data_s;
  logic w_clk_fall;
  logic w_timeout;
  logic w_waiting;

  assign w_clk_s    = r_clk_sync[1];
  assign w_data_s   = r_data_sync[1];
  assign w_clk_fall = r_clk_prev & ~w_clk_s;
  assign w_timeout  = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_waiting  = (r_state == S_REQ) || (r_state == S_SHIFT) ||
                      (r_state == S_ACK) || (r_state == S_END);

  // NOTE: synchronizers reset to 1, the idle level of the open-drain lines,
  // so leaving reset can never look like a falling edge.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      r_clk_sync  <= {r_clk_sync[0], kbd_clk_in};
      r_data_sync <= {r_data_sync[0], kbd_data_in};
      r_clk_prev  <= r_clk_sync[1];
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= S_IDLE;
      r_frame   <= '0;
      r_bit     <= '0;
      r_inh     <= '0;
      r_tmo     <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_waiting && w_timeout) begin
        r_err     <= 1'b1;
        r_clk_oe  <= 1'b0;
        r_data_oe <= 1'b0;
        r_busy    <= 1'b0;
        r_ready   <= 1'b1;
        r_state   <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (tx.tx_valid && r_ready) begin
              r_frame  <= {~^tx.tx_data, tx.tx_data};
              r_bit    <= '0;
              r_inh    <= '0;
              r_tmo    <= '0;
              r_clk_oe <= 1'b1;
              r_ready  <= 1'b0;
              r_busy   <= 1'b1;
              r_state  <= S_INHIBIT;
            end else begin
              r_ready <= 1'b1;
            end
          end
          S_INHIBIT: begin
            r_inh <= r_inh + 1'b1;
            // Start bit goes out one cycle before the clock is released.
            if (r_inh == IW'(INHIBIT_CYCLES - 2)) r_data_oe <= 1'b1;
            if (r_inh == IW'(INHIBIT_CYCLES - 1)) begin
              r_clk_oe  <= 1'b0;
              r_data_oe <= 1'b1;
              r_state   <= S_REQ;
            end
          end
          S_REQ, S_SHIFT: begin
            r_tmo <= r_tmo + 1'b1;
            if (w_clk_fall) begin
              r_bit <= r_bit + 1'b1;
              if (r_bit == 4'd9) begin
                r_data_oe <= 1'b0;
                r_state   <= S_ACK;
              end else begin
                r_data_oe <= ~r_frame[r_bit];
                r_state   <= S_SHIFT;
              end
            end
          end
          S_ACK: begin
            r_tmo <= r_tmo + 1'b1;
            if (w_clk_fall) begin
              r_done  <= ~w_data_s;
              r_err   <= w_data_s;
              r_state <= S_END;
            end
          end
          S_END: begin
            r_tmo <= r_tmo + 1'b1;
            if (w_clk_s && w_data_s) begin
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign kbd_clk_oe  = r_clk_oe;
  assign kbd_data_oe = r_data_oe;
  assign tx.tx_ready = r_ready;
  assign tx.tx_busy  = r_busy;
  assign tx.tx_done  = r_done;
  assign tx.tx_err   = r_err;

endmodule

// File: tb/tb_big_core_kbd_tx.sv
// Bench for big_core_kbd_tx: an open-drain PS/2 device model clocks frames out of
// the transmitter and the sampled bits are compared with a frame model.
module tb_big_core_kbd_tx;

  localparam int INH  = 10;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic Clk = 1'b0;
  logic Rst;
  logic kbd_clk_oe;
  logic kbd_data_oe;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic line_clk;
  logic line_data;

  always #5 Clk = ~Clk;

  big_core_kbd_tx_if tx_if ();

  assign line_clk  = ~kbd_clk_oe & ~dev_clk_low;
  assign line_data = ~kbd_data_oe & ~dev_data_low;

  big_core_kbd_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .tx         (tx_if),
    .kbd_clk_in (line_clk),
    .kbd_data_in(line_data),
    .kbd_clk_oe (kbd_clk_oe),
    .kbd_data_oe(kbd_data_oe)
  );

  int tests = 0;
  int fails = 0;

  int         n_done    = 0;
  int         n_err     = 0;
  int         n_clk_oe  = 0;
  int         cyc       = 0;
  bit         both_seen = 1'b0;
  logic [7:0] acc_q[$];

  // Sampled one time unit after the falling clock edge, once per cycle.
  always @(negedge Clk) begin
    #1;
    cyc++;
    if (tx_if.tx_done === 1'b1) n_done++;
    if (tx_if.tx_err === 1'b1) n_err++;
    if (tx_if.tx_done === 1'b1 && tx_if.tx_err === 1'b1) both_seen = 1'b1;
    if (kbd_clk_oe === 1'b1) n_clk_oe++;
    if (tx_if.tx_ready === 1'b1 && tx_if.tx_valid === 1'b1) acc_q.push_back(tx_if.tx_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 2000000", $time);
    $fatal(1);
  end

  // Frame as the device should see it: bits[7:0] data LSB first, [8] odd parity, [9] stop.
  function automatic logic [9:0] ref_frame(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d};
  endfunction

  task automatic start_byte(input logic [7:0] d, output bit ok);
    ok = 1'b0;
    @(negedge Clk);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      #2;
      if (tx_if.tx_busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic dev_xfer(input int n_pulses, input bit ack_low,
                          output logic [9:0] bits, output bit ok);
    ok   = 1'b0;
    bits = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      #2;
      if (kbd_clk_oe === 1'b0 && kbd_data_oe === 1'b1 && tx_if.tx_busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      for (int k = 1; k <= n_pulses; k++) begin
        @(negedge Clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge Clk);
        if (k <= 10) bits[k-1] = line_data;
        dev_clk_low = 1'b0;
        if (k == 10 && ack_low) dev_data_low = 1'b1;
        repeat (HALF) @(negedge Clk);
        if (k == 11) dev_data_low = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge Clk);
      #2;
      if (tx_if.tx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_xfer(input logic [7:0] d, input bit ack_low,
                          output logic [9:0] bits, output bit ok);
    bit a_ok, d_ok, i_ok;
    start_byte(d, a_ok);
    dev_xfer(11, ack_low, bits, d_ok);
    wait_idle(i_ok);
    ok = a_ok & d_ok & i_ok;
  endtask

  task automatic test_reset;
    logic [5:0] outs;
    Rst            = 1'b1;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    repeat (3) @(negedge Clk);
    #2;
    outs = {tx_if.tx_ready, tx_if.tx_busy, tx_if.tx_done, tx_if.tx_err, kbd_clk_oe, kbd_data_oe};
    tests++;
    if (outs !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b, required 000000", outs);
    end
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    #2;
    tests++;
    if (tx_if.tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: got %b, required 1", tx_if.tx_ready);
    end
  endtask

  task automatic test_ed;
    logic [9:0] bits;
    bit         ok;
    int d0 = n_done, e0 = n_err, c0 = n_clk_oe;
    run_xfer(8'hED, 1'b1, bits, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL ed_handshake: got ok=%b, required 1", ok);
    end
    tests++;
    if (bits !== 10'b11_1110_1101) begin
      fails++;
      $display("FAIL ed_bits: got %b, required %b", bits, 10'b11_1110_1101);
    end
    tests++;
    if (n_clk_oe - c0 !== INH) begin
      fails++;
      $display("FAIL ed_inhibit_len: got %0d, required %0d", n_clk_oe - c0, INH);
    end
    tests++;
    if (n_done - d0 !== 1 || n_err - e0 !== 0) begin
      fails++;
      $display("FAIL ed_pulses: got done=%0d err=%0d, required done=1 err=0", n_done - d0, n_err - e0);
    end
    tests++;
    if (tx_if.tx_ready !== 1'b1 || tx_if.tx_busy !== 1'b0) begin
      fails++;
      $display("FAIL ed_idle: got ready=%b busy=%b, required ready=1 busy=0", tx_if.tx_ready, tx_if.tx_busy);
    end
  endtask

  task automatic test_parity;
    logic [9:0] bits;
    bit         ok;
    run_xfer(8'h01, 1'b1, bits, ok);
    tests++;
    if (!ok || bits[8] !== 1'b0) begin
      fails++;
      $display("FAIL parity_01: got ok=%b parity=%b, required ok=1 parity=0", ok, bits[8]);
    end
    run_xfer(8'h00, 1'b1, bits, ok);
    tests++;
    if (!ok || bits !== ref_frame(8'h00) || bits[8] !== 1'b1) begin
      fails++;
      $display("FAIL parity_00: got ok=%b frame=%b, required ok=1 frame=%b", ok, bits, ref_frame(8'h00));
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int t_req = -1, t_err = -1;
    int d0 = n_done, e0 = n_err;
    start_byte(8'h5A, ok);
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      #2;
      if (kbd_clk_oe === 1'b0 && kbd_data_oe === 1'b1) begin
        t_req = cyc;
        break;
      end
    end
    for (int i = 0; i < TMO + 200; i++) begin
      @(negedge Clk);
      #2;
      if (n_err > e0) begin
        t_err = cyc;
        break;
      end
    end
    tests++;
    if (!ok || t_req < 0 || t_err - t_req !== TMO) begin
      fails++;
      $display("FAIL timeout_delay: got ok=%b delay=%0d, required ok=1 delay=%0d", ok, t_err - t_req, TMO);
    end
    tests++;
    if (kbd_clk_oe !== 1'b0 || kbd_data_oe !== 1'b0) begin
      fails++;
      $display("FAIL timeout_release: got clk_oe=%b data_oe=%b, required 0 0", kbd_clk_oe, kbd_data_oe);
    end
    repeat (20) @(negedge Clk);
    #2;
    tests++;
    if (n_err - e0 !== 1 || n_done - d0 !== 0 || tx_if.tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL timeout_pulses: got err=%0d done=%0d ready=%b, required err=1 done=0 ready=1",
               n_err - e0, n_done - d0, tx_if.tx_ready);
    end
  endtask

  task automatic test_nack;
    logic [9:0] bits;
    bit         ok;
    int d0 = n_done, e0 = n_err;
    run_xfer(8'h96, 1'b0, bits, ok);
    tests++;
    if (!ok || bits !== ref_frame(8'h96)) begin
      fails++;
      $display("FAIL nack_frame: got ok=%b frame=%b, required ok=1 frame=%b", ok, bits, ref_frame(8'h96));
    end
    tests++;
    if (n_err - e0 !== 1 || n_done - d0 !== 0) begin
      fails++;
      $display("FAIL nack_pulses: got err=%0d done=%0d, required err=1 done=0", n_err - e0, n_done - d0);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] b1, b2;
    bit ok1, ok2, ok_a, ok_i;
    int base = acc_q.size();
    int d0 = n_done;
    ok_a = 1'b0;
    @(negedge Clk);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'hAA;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge Clk);
          #2;
          if (tx_if.tx_busy === 1'b1) break;
        end
        tx_if.tx_data = 8'h55;
        for (int i = 0; i < 1500; i++) begin
          @(negedge Clk);
          #2;
          if (acc_q.size() >= base + 2 && tx_if.tx_busy === 1'b1) begin
            ok_a = 1'b1;
            break;
          end
        end
        tx_if.tx_valid = 1'b0;
      end
      begin
        dev_xfer(11, 1'b1, b1, ok1);
        dev_xfer(11, 1'b1, b2, ok2);
      end
    join
    wait_idle(ok_i);
    tests++;
    if (!(ok_a && ok1 && ok2 && ok_i) || acc_q.size() !== base + 2) begin
      fails++;
      $display("FAIL b2b_accepts: got count=%0d ok=%b%b%b%b, required count=2 ok=1111",
               acc_q.size() - base, ok_a, ok1, ok2, ok_i);
    end else begin
      tests++;
      if (acc_q[base] !== 8'hAA || acc_q[base+1] !== 8'h55) begin
        fails++;
        $display("FAIL b2b_order: got %h %h, required aa 55", acc_q[base], acc_q[base+1]);
      end
    end
    tests++;
    if (b1 !== ref_frame(8'hAA) || b2 !== ref_frame(8'h55) || n_done - d0 !== 2) begin
      fails++;
      $display("FAIL b2b_frames: got %b %b done=%0d, required %b %b done=2",
               b1, b2, n_done - d0, ref_frame(8'hAA), ref_frame(8'h55));
    end
  endtask

  task automatic test_reset_mid;
    logic [9:0] bits;
    bit ok_a, ok_d, ok;
    int d0, e0;
    start_byte(8'hE5, ok_a);
    dev_xfer(5, 1'b0, bits, ok_d);
    d0 = n_done;
    e0 = n_err;
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    tests++;
    if (!(ok_a && ok_d) || kbd_clk_oe !== 1'b0 || kbd_data_oe !== 1'b0) begin
      fails++;
      $display("FAIL midreset_release: got ok=%b%b clk_oe=%b data_oe=%b, required ok=11 0 0",
               ok_a, ok_d, kbd_clk_oe, kbd_data_oe);
    end
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    repeat (5) @(negedge Clk);
    #2;
    tests++;
    if (n_done !== d0 || n_err !== e0) begin
      fails++;
      $display("FAIL midreset_pulses: got done=%0d err=%0d, required done=0 err=0", n_done - d0, n_err - e0);
    end
    d0 = n_done;
    run_xfer(8'h3C, 1'b1, bits, ok);
    tests++;
    if (!ok || bits !== ref_frame(8'h3C) || n_done - d0 !== 1) begin
      fails++;
      $display("FAIL midreset_recover: got ok=%b frame=%b done=%0d, required ok=1 frame=%b done=1",
               ok, bits, n_done - d0, ref_frame(8'h3C));
    end
  endtask

  task automatic test_random;
    logic [9:0] bits;
    logic [7:0] d;
    bit ok, ack;
    int d0, e0;
    for (int i = 0; i < 4; i++) begin
      d   = 8'($urandom);
      ack = 1'($urandom_range(0, 1));
      d0  = n_done;
      e0  = n_err;
      run_xfer(d, ack, bits, ok);
      tests++;
      if (!ok || bits !== ref_frame(d) || n_done - d0 !== int'(ack) || n_err - e0 !== int'(!ack)) begin
        fails++;
        $display("FAIL random_%0d: data=%h ack=%b got ok=%b frame=%b done=%0d err=%0d, required frame=%b",
                 i, d, ack, ok, bits, n_done - d0, n_err - e0, ref_frame(d));
      end
    end
  endtask

  task automatic test_exclusive;
    tests++;
    if (both_seen !== 1'b0) begin
      fails++;
      $display("FAIL done_err_exclusive: got both=%b, required 0", both_seen);
    end
  endtask

  initial begin
    test_reset;
    test_ed;
    test_parity;
    test_timeout;
    test_nack;
    test_back_to_back;
    test_reset_mid;
    test_random;
    test_exclusive;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
